// File: rtl/mem_pkg.sv
// Shared types for the two-stage load/store pipe: access-size codes,
// the M0->M1 stage bundle and a byte-enable helper.
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef struct packed {
        logic        valid;
        logic        ld;
        logic        st;
        logic [1:0]  size;
        logic        sgn;
        logic        misal;
        logic        wreg;
        logic [1:0]  lane;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] wbval;
    } m0_m1_t;

    // Size code 11 behaves as a word access.
    function automatic logic [3:0] lane_be(
        input logic [1:0] size,
        input logic [1:0] lane
    );
        logic [3:0] be;
        be = 4'b0000;
        unique case (1'b1)
            size[1]:           be = 4'b1111;
            (size == SZ_HALF): be = lane[1] ? 4'b1100 : 4'b0011;
            default:           be = 4'b0001 << lane;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/mem_pipe_if.sv
// Issue-side and writeback-side bundle of the memory pipe.
// master: issue unit / bench; slave: mem_pipe.
// mem_wb_misalign exists only when MEM_MISALIGN_TRAP_EN is defined.
interface mem_pipe_if #(
    parameter int REGDEST_W = 5
);

    logic                 iss_mem_oper;
    logic                 mem_iss_ready;
    logic                 iss_mem_readmem;
    logic                 iss_mem_writemem;
    logic [1:0]           iss_mem_size;
    logic                 iss_mem_signed;
    logic [31:0]          iss_mem_rega;
    logic [31:0]          iss_mem_imedext;
    logic [31:0]          iss_mem_regb;
    logic [31:0]          iss_mem_wbvalue;
    logic [REGDEST_W-1:0] iss_mem_regdest;
    logic                 iss_mem_writereg;

    logic                 mem_wb_oper;
    logic                 mem_wb_writereg;
    logic [REGDEST_W-1:0] mem_wb_regdest;
    logic [31:0]          mem_wb_wbvalue;
`ifdef MEM_MISALIGN_TRAP_EN
    logic                 mem_wb_misalign;
`endif

    modport master (
        output iss_mem_oper, iss_mem_readmem, iss_mem_writemem,
        output iss_mem_size, iss_mem_signed, iss_mem_rega,
        output iss_mem_imedext, iss_mem_regb, iss_mem_wbvalue,
        output iss_mem_regdest, iss_mem_writereg,
`ifdef MEM_MISALIGN_TRAP_EN
        input  mem_wb_misalign,
`endif
        input  mem_iss_ready, mem_wb_oper, mem_wb_writereg,
        input  mem_wb_regdest, mem_wb_wbvalue
    );

    modport slave (
        input  iss_mem_oper, iss_mem_readmem, iss_mem_writemem,
        input  iss_mem_size, iss_mem_signed, iss_mem_rega,
        input  iss_mem_imedext, iss_mem_regb, iss_mem_wbvalue,
        input  iss_mem_regdest, iss_mem_writereg,
`ifdef MEM_MISALIGN_TRAP_EN
        output mem_wb_misalign,
`endif
        output mem_iss_ready, mem_wb_oper, mem_wb_writereg,
        output mem_wb_regdest, mem_wb_wbvalue
    );

endinterface

// File: rtl/mem_pipe_ram.sv
// DEPTH x 32 data RAM: byte-enabled synchronous write, combinational read.
// Ports: init_* full-word preload (wins), pipe_* byte-lane store, rd_* read.
module mem_pipe_ram #(
    parameter int DEPTH = 1024
) (
    input  logic                     clock,
    input  logic                     init_we_i,
    input  logic [$clog2(DEPTH)-1:0] init_addr_i,
    input  logic [31:0]              init_data_i,
    input  logic                     pipe_we_i,
    input  logic [3:0]               pipe_be_i,
    input  logic [$clog2(DEPTH)-1:0] pipe_addr_i,
    input  logic [31:0]              pipe_data_i,
    input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
    output logic [31:0]              rd_data_o
);

    localparam int AW = $clog2(DEPTH);

    logic [31:0]   mem_q [DEPTH];
    logic [3:0]    we_be;
    logic [AW-1:0] waddr;
    logic [31:0]   wdata;

    always_comb begin
        we_be = 4'b0000;
        waddr = pipe_addr_i;
        wdata = pipe_data_i;
        if (init_we_i) begin
            we_be = 4'b1111;
            waddr = init_addr_i;
            wdata = init_data_i;
        end else if (pipe_we_i) begin
            we_be = pipe_be_i;
        end
    end

    // Contents deliberately survive reset.
    always_ff @(posedge clock) begin
        for (int i = 0; i < 4; i++) begin
            if (we_be[i]) begin
                mem_q[waddr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/mem_pipe.sv
// Two-stage load/store pipe. M0: address add, alignment, lanes, store data.
// M1: RAM write/read. Output register: load extract/extend, writeback.
// Ports: clock, reset (async active-low), bus (mem_pipe_if.slave),
// ram_init_en/addr/data preload. Option: MEM_MISALIGN_TRAP_EN.
module mem_pipe
    import mem_pkg::*;
#(
    parameter int DEPTH     = 1024,
    parameter int REGDEST_W = 5
) (
    input  logic                     clock,
    input  logic                     reset,
    mem_pipe_if.slave                bus,
    input  logic                     ram_init_en,
    input  logic [$clog2(DEPTH)-1:0] ram_init_addr,
    input  logic [31:0]              ram_init_data
);

    localparam int AW = $clog2(DEPTH);

    logic                 accept;
    logic [31:0]          sum;
    logic                 is_ld;
    logic                 is_st;
    logic                 sz_word;
    logic                 sz_half;

    m0_m1_t               m0_d;
    m0_m1_t               m0_q;
    m0_m1_t               m1_q;
    logic [REGDEST_W-1:0] m0_rd_q;
    logic [REGDEST_W-1:0] m1_rd_q;
    logic [31:0]          m1_rdata_q;
    logic [31:0]          ram_rdata;
    logic                 pipe_we;

    logic [7:0]           byte_v;
    logic [15:0]          half_v;
    logic [31:0]          ld_v;
    logic [31:0]          wb_d;

    logic                 oper_q;
    logic                 wreg_q;
    logic [REGDEST_W-1:0] rd_q;
    logic [31:0]          wbv_q;

    logic                 unused_bits;

    assign bus.mem_iss_ready = !ram_init_en;
    assign accept = bus.iss_mem_oper && !ram_init_en;

    // ---------------- M0 formation ----------------
    always_comb begin
        sum     = bus.iss_mem_rega + bus.iss_mem_imedext;
        is_ld   = bus.iss_mem_readmem;
        is_st   = bus.iss_mem_writemem & ~bus.iss_mem_readmem;
        sz_word = bus.iss_mem_size[1];
        sz_half = (bus.iss_mem_size == SZ_HALF);

        m0_d       = '0;
        m0_d.valid = accept;
        m0_d.ld    = is_ld;
        m0_d.st    = is_st;
        m0_d.size  = bus.iss_mem_size;
        m0_d.sgn   = bus.iss_mem_signed;
        m0_d.wreg  = bus.iss_mem_writereg;
        m0_d.addr  = sum;
        m0_d.wbval = bus.iss_mem_wbvalue;
`ifdef MEM_MISALIGN_TRAP_EN
        m0_d.misal = (is_ld | is_st)
                   & ((sz_half & sum[0])
                   | (sz_word & (sum[1:0] != 2'b00)));
        m0_d.lane  = sum[1:0];
`else
        m0_d.misal = 1'b0;
        unique case (1'b1)
            sz_word: m0_d.lane = 2'b00;
            sz_half: m0_d.lane = {sum[1], 1'b0};
            default: m0_d.lane = sum[1:0];
        endcase
`endif
        m0_d.be = lane_be(bus.iss_mem_size, m0_d.lane);
        // Replicated data; the byte enables pick the live lanes.
        unique case (1'b1)
            sz_word: m0_d.wdata = bus.iss_mem_regb;
            sz_half: m0_d.wdata = {2{bus.iss_mem_regb[15:0]}};
            default: m0_d.wdata = {4{bus.iss_mem_regb[7:0]}};
        endcase
    end

    // Preload freezes M0 so a held op is neither lost nor duplicated.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            m0_q    <= '0;
            m0_rd_q <= '0;
        end else if (!ram_init_en) begin
            m0_q    <= m0_d;
            m0_rd_q <= bus.iss_mem_regdest;
        end
    end

    // ---------------- M1: RAM access ----------------
    assign pipe_we = m0_q.valid & m0_q.st & ~m0_q.misal;

    mem_pipe_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clock       (clock),
        .init_we_i   (ram_init_en),
        .init_addr_i (ram_init_addr),
        .init_data_i (ram_init_data),
        .pipe_we_i   (pipe_we),
        .pipe_be_i   (m0_q.be),
        .pipe_addr_i (m0_q.addr[AW+1:2]),
        .pipe_data_i (m0_q.wdata),
        .rd_addr_i   (m0_q.addr[AW+1:2]),
        .rd_data_o   (ram_rdata)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            m1_q       <= '0;
            m1_rd_q    <= '0;
            m1_rdata_q <= '0;
        end else if (ram_init_en) begin
            m1_q       <= '0;
        end else begin
            m1_q       <= m0_q;
            m1_rd_q    <= m0_rd_q;
            m1_rdata_q <= ram_rdata;
        end
    end

    // ---------------- Output register ----------------
    always_comb begin
        unique case (m1_q.lane)
            2'd0:    byte_v = m1_rdata_q[7:0];
            2'd1:    byte_v = m1_rdata_q[15:8];
            2'd2:    byte_v = m1_rdata_q[23:16];
            default: byte_v = m1_rdata_q[31:24];
        endcase
        half_v = m1_q.lane[1] ? m1_rdata_q[31:16] : m1_rdata_q[15:0];

        unique case (1'b1)
            m1_q.size[1]:
                ld_v = m1_rdata_q;
            (m1_q.size == SZ_HALF):
                ld_v = {{16{m1_q.sgn & half_v[15]}}, half_v};
            default:
                ld_v = {{24{m1_q.sgn & byte_v[7]}}, byte_v};
        endcase

        wb_d = 32'h0;
        if (m1_q.valid && !m1_q.misal && !m1_q.st) begin
            wb_d = m1_q.ld ? ld_v : m1_q.wbval;
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    logic mis_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mis_q <= 1'b0;
        end else begin
            mis_q <= m1_q.valid & m1_q.misal;
        end
    end

    assign bus.mem_wb_misalign = mis_q;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            oper_q <= 1'b0;
            wreg_q <= 1'b0;
            rd_q   <= '0;
            wbv_q  <= '0;
        end else begin
            oper_q <= m1_q.valid;
            wreg_q <= m1_q.valid & m1_q.wreg & ~m1_q.misal;
            rd_q   <= m1_q.valid ? m1_rd_q : '0;
            wbv_q  <= wb_d;
        end
    end

    assign bus.mem_wb_oper     = oper_q;
    assign bus.mem_wb_writereg = wreg_q;
    assign bus.mem_wb_regdest  = rd_q;
    assign bus.mem_wb_wbvalue  = wbv_q;

    assign unused_bits = ^{m1_q.addr, m1_q.be, m1_q.wdata,
                           m0_q.addr[31:AW+2], m0_q.addr[1:0]};

endmodule

// File: tb/tb_mem_pipe.sv
// Directed bench for mem_pipe: hand-computed vectors checked through a
// two-deep expected-output delay line with immediate assertions.
module tb_mem_pipe;
    import mem_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        ram_init_en;
    logic [9:0]  ram_init_addr;
    logic [31:0] ram_init_data;

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic        v;
        logic [31:0] val;
        logic        wr;
        logic [4:0]  rd;
        logic        mis;
    } exp_t;

    exp_t e0, e1, e2, cur;

    always #5 clock = ~clock;

    mem_pipe_if #(.REGDEST_W(5)) bus ();

    mem_pipe #(
        .DEPTH     (1024),
        .REGDEST_W (5)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .bus           (bus),
        .ram_init_en   (ram_init_en),
        .ram_init_addr (ram_init_addr),
        .ram_init_data (ram_init_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        n_vec++;
        assert (obs === expv)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic issue(input logic rdm, input logic wrm,
                         input logic [1:0] sz, input logic sgn,
                         input logic [31:0] a, input logic [31:0] imm,
                         input logic [31:0] b, input logic [31:0] wbv,
                         input logic [4:0] rd, input logic wreg,
                         input logic [31:0] xv, input logic xmis);
        bus.iss_mem_oper     = 1'b1;
        bus.iss_mem_readmem  = rdm;
        bus.iss_mem_writemem = wrm;
        bus.iss_mem_size     = sz;
        bus.iss_mem_signed   = sgn;
        bus.iss_mem_rega     = a;
        bus.iss_mem_imedext  = imm;
        bus.iss_mem_regb     = b;
        bus.iss_mem_wbvalue  = wbv;
        bus.iss_mem_regdest  = rd;
        bus.iss_mem_writereg = wreg;
        cur.v   = 1'b1;
        cur.val = xv;
        cur.wr  = wreg;
        cur.rd  = rd;
        cur.mis = xmis;
    endtask

    task automatic ld(input logic [1:0] sz, input logic sgn,
                      input logic [31:0] a, input logic [4:0] rd,
                      input logic [31:0] xv);
        issue(1'b1, 1'b0, sz, sgn, a, 32'h0, 32'h0, 32'h0,
              rd, 1'b1, xv, 1'b0);
    endtask

    task automatic st(input logic [1:0] sz, input logic [31:0] a,
                      input logic [31:0] d);
        issue(1'b0, 1'b1, sz, 1'b0, a, 32'h0, d, 32'h0,
              5'd0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic idle();
        bus.iss_mem_oper = 1'b0;
    endtask

    // One clock; the delay line mirrors the documented 2-edge latency,
    // with init cycles holding M0 and inserting a bubble.
    task automatic tick();
        @(posedge clock);
        e2 = e1;
        if (ram_init_en) begin
            e1 = '0;
        end else begin
            e1 = e0;
            e0 = bus.iss_mem_oper ? cur : '0;
        end
        #1;
        chk("oper", {31'h0, bus.mem_wb_oper}, {31'h0, e2.v});
        chk("writereg", {31'h0, bus.mem_wb_writereg},
            {31'h0, e2.v & e2.wr & ~e2.mis});
`ifdef MEM_MISALIGN_TRAP_EN
        chk("misalign", {31'h0, bus.mem_wb_misalign},
            {31'h0, e2.v & e2.mis});
`endif
        if (e2.v) begin
            chk("wbvalue", bus.mem_wb_wbvalue, e2.val);
            chk("regdest", {27'h0, bus.mem_wb_regdest}, {27'h0, e2.rd});
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_oper"}, {31'h0, bus.mem_wb_oper}, 32'h0);
        chk({tag, "_wreg"}, {31'h0, bus.mem_wb_writereg}, 32'h0);
        chk({tag, "_rd"}, {27'h0, bus.mem_wb_regdest}, 32'h0);
        chk({tag, "_wbv"}, bus.mem_wb_wbvalue, 32'h0);
`ifdef MEM_MISALIGN_TRAP_EN
        chk({tag, "_mis"}, {31'h0, bus.mem_wb_misalign}, 32'h0);
`endif
    endtask

    initial begin
        reset         = 1'b1;
        ram_init_en   = 1'b0;
        ram_init_addr = '0;
        ram_init_data = '0;
        e0 = '0; e1 = '0; e2 = '0; cur = '0;
        issue(1'b0, 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0,
              5'd0, 1'b0, 32'h0, 1'b0);
        idle();

        // Reset state
        #1 reset = 1'b0;
        #1;
        chk_zero("reset");
        chk("ready_idle", {31'h0, bus.mem_iss_ready}, 32'h1);
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;

        // Preload words 5, 16 and 8
        ram_init_en   = 1'b1;
        ram_init_addr = 10'd5;
        ram_init_data = 32'h8899AABB;
        #1 chk("ready_init", {31'h0, bus.mem_iss_ready}, 32'h0);
        tick();
        ram_init_addr = 10'd16;
        ram_init_data = 32'h11112222;
        tick();
        ram_init_addr = 10'd8;
        ram_init_data = 32'h00000000;
        tick();
        ram_init_en = 1'b0;
        #1 chk("ready_back", {31'h0, bus.mem_iss_ready}, 32'h1);

        // Word load via base+offset; single-cycle oper pulse
        issue(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h4, 32'h0, 32'h0,
              5'd3, 1'b1, 32'h8899AABB, 1'b0);
        tick(); idle();
        tick(); tick(); tick(); tick();

        // Byte store then signed byte loads across the word
        st(SZ_BYTE, 32'h15, 32'h0000007F);           tick();
        ld(SZ_BYTE, 1'b1, 32'h14, 5'd1, 32'hFFFFFFBB); tick();
        ld(SZ_BYTE, 1'b1, 32'h15, 5'd2, 32'h0000007F); tick();
        ld(SZ_BYTE, 1'b1, 32'h16, 5'd3, 32'hFFFFFF99); tick();
        ld(SZ_BYTE, 1'b1, 32'h17, 5'd4, 32'hFFFFFF88); tick();

        // Halves, unsigned byte, pass-through, address wrap
        ld(SZ_HALF, 1'b0, 32'h16, 5'd5, 32'h00008899); tick();
        ld(SZ_HALF, 1'b1, 32'h14, 5'd6, 32'h00007FBB); tick();
        ld(SZ_HALF, 1'b1, 32'h16, 5'd7, 32'hFFFF8899); tick();
        ld(SZ_BYTE, 1'b0, 32'h17, 5'd8, 32'h00000088); tick();
        issue(1'b0, 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0, 32'h0,
              32'h000055AA, 5'd9, 1'b1, 32'h000055AA, 1'b0);
        tick();
        issue(1'b1, 1'b0, SZ_WORD, 1'b0, 32'hFFFFFFF0, 32'h24,
              32'h0, 32'h0, 5'd10, 1'b1, 32'h88997FBB, 1'b0);
        tick();
        ld(SZ_WORD, 1'b0, 32'h1014, 5'd11, 32'h88997FBB); tick();

        // Store word then immediate reload; size 11; read+write = load
        st(SZ_WORD, 32'h20, 32'h12345678);             tick();
        ld(SZ_WORD, 1'b0, 32'h20, 5'd12, 32'h12345678); tick();
        ld(2'b11, 1'b0, 32'h20, 5'd13, 32'h12345678);   tick();
        issue(1'b1, 1'b1, SZ_WORD, 1'b0, 32'h20, 32'h0, 32'hFFFFFFFF,
              32'h0, 5'd14, 1'b1, 32'h12345678, 1'b0);
        tick();
        ld(SZ_WORD, 1'b0, 32'h20, 5'd15, 32'h12345678); tick();
        idle(); tick(); tick();

        // Misaligned accesses
`ifdef MEM_MISALIGN_TRAP_EN
        issue(1'b0, 1'b1, SZ_WORD, 1'b0, 32'h22, 32'h0, 32'hAAAAAAAA,
              32'h0, 5'd0, 1'b0, 32'h0, 1'b1);
        tick();
        issue(1'b1, 1'b0, SZ_HALF, 1'b1, 32'h21, 32'h0, 32'h0, 32'h0,
              5'd16, 1'b1, 32'h0, 1'b1);
        tick();
        ld(SZ_WORD, 1'b0, 32'h20, 5'd17, 32'h12345678); tick();
`else
        st(SZ_WORD, 32'h22, 32'hAAAAAAAA);              tick();
        ld(SZ_HALF, 1'b1, 32'h21, 5'd16, 32'hFFFFAAAA);  tick();
        ld(SZ_WORD, 1'b0, 32'h20, 5'd17, 32'hAAAAAAAA);  tick();
`endif
        idle(); tick(); tick();

        // Preload while an op sits in M0
        ld(SZ_WORD, 1'b0, 32'h14, 5'd18, 32'h88997FBB); tick();
        idle();
        ram_init_en   = 1'b1;
        ram_init_addr = 10'd9;
        ram_init_data = 32'hCAFE0009;
        #1 chk("ready_hold", {31'h0, bus.mem_iss_ready}, 32'h0);
        tick();
        ram_init_addr = 10'd10;
        ram_init_data = 32'hCAFE000A;
        tick();
        ram_init_addr = 10'd11;
        ram_init_data = 32'hCAFE000B;
        tick();
        ram_init_en = 1'b0;
        tick(); tick();
        ld(SZ_WORD, 1'b0, 32'h28, 5'd19, 32'hCAFE000A); tick();
        ld(SZ_WORD, 1'b0, 32'h24, 5'd20, 32'hCAFE0009); tick();
        ld(SZ_WORD, 1'b0, 32'h2C, 5'd21, 32'hCAFE000B); tick();
        idle(); tick(); tick();

        // Reset with a load and a store in flight
        issue(1'b0, 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0, 32'h0,
              32'h0BAD0BAD, 5'd4, 1'b1, 32'h0BAD0BAD, 1'b0);
        tick();
        ld(SZ_WORD, 1'b0, 32'h40, 5'd5, 32'h11112222); tick();
        st(SZ_WORD, 32'h40, 32'hDEADBEEF);             tick();
        idle();
        reset = 1'b0;
        #1;
        chk_zero("async_rst");
        e0 = '0; e1 = '0; e2 = '0;
        tick(); tick();
        reset = 1'b1;
        tick(); tick(); tick();
        ld(SZ_WORD, 1'b0, 32'h40, 5'd6, 32'h11112222); tick();
        idle(); tick(); tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_pipe.md
MEM_PIPE -- requirements
Module: mem_pipe

Interface
REQ-001 Parameter DEPTH, default 1024, data RAM depth in 32-bit words; SHALL be a power of two, at least 4.
REQ-002 Parameter REGDEST_W, default 5, width of the writeback register index.
REQ-003 clock  in  1  single clock; all state changes on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 iss_mem_oper  in  1  issue-valid; an op is accepted when iss_mem_oper=1 and mem_iss_ready=1 at a rising edge.
REQ-006 mem_iss_ready  out  1  stage can accept an op this cycle.
REQ-007 iss_mem_readmem / iss_mem_writemem  in  1 each  load / store; both 0 means pass-through op; both 1 is treated as a load.
REQ-008 iss_mem_size  in  2  00 byte, 01 half, 10 word, 11 treated as word.
REQ-009 iss_mem_signed  in  1  sign-extend sub-word loads when 1, zero-extend when 0.
REQ-010 iss_mem_rega, iss_mem_imedext  in  32 each  base and offset; byte address = sum mod 2^32.
REQ-011 iss_mem_regb  in  32  store data, low bytes used for sub-word stores.
REQ-012 iss_mem_wbvalue  in  32  execute result forwarded for pass-through ops.
REQ-013 iss_mem_regdest  in  REGDEST_W; iss_mem_writereg  in  1  forwarded to writeback.
REQ-014 ram_init_en, ram_init_addr [log2(DEPTH)-1:0], ram_init_data [31:0]  in  synchronous full-word preload port.
REQ-015 mem_wb_oper, mem_wb_writereg  out  1 each; mem_wb_regdest  out  REGDEST_W; mem_wb_wbvalue  out  32.
REQ-016 mem_wb_misalign  out  1  present only when MEM_MISALIGN_TRAP_EN is defined.

Function
REQ-017 Two registered stages: M0 (address add, alignment check, byte-lane and store-data formation), M1 (RAM access, load extraction and extension, output register).
REQ-018 Op accepted at edge N SHALL appear on mem_wb_* after edge N+2 (latency 2), one op per cycle sustained throughput.
REQ-019 mem_wb_oper SHALL be 1 for exactly one cycle per accepted op; mem_wb_writereg SHALL equal the op's iss_mem_writereg gated by mem_wb_oper.
REQ-020 Word index = byte address bits [log2(DEPTH)+1:2]; higher bits ignored (address wraps modulo 4*DEPTH).
REQ-021 Little-endian: byte lane = addr[1:0], half lane = addr[1]; store writes only the selected bytes, other bytes unchanged.
REQ-022 Load result: selected byte/half right-justified, extended per iss_mem_signed; word load returns the full word.
REQ-023 Store result: mem_wb_wbvalue = 0; pass-through result: mem_wb_wbvalue = iss_mem_wbvalue.
REQ-024 RAM write occurs at the M1 edge; a load immediately following a store to the same word SHALL return the updated data (in-order, no forwarding hazard).
REQ-025 ram_init_en=1: mem_iss_ready=0, M0 holds its contents, M1 receives a bubble, RAM word ram_init_addr <= ram_init_data; init has priority over any pipeline access.
REQ-026 mem_iss_ready = !ram_init_en otherwise (combinational).
REQ-027 RAM contents SHALL NOT be cleared by reset.

Reset
REQ-028 reset=0 SHALL asynchronously clear both stage valids, mem_wb_oper, mem_wb_writereg, mem_wb_regdest, mem_wb_wbvalue, mem_wb_misalign to 0; in-flight ops are discarded, in-flight stores not written.

Configuration
REQ-029 Macro MEM_MISALIGN_TRAP_EN defined: half with addr[0]=1 or word with addr[1:0]!=0 is misaligned; store suppressed, mem_wb_writereg=0, mem_wb_wbvalue=0, mem_wb_misalign=1 for that op's output cycle.
REQ-030 Macro undefined: no misalign port; low address bits are forced to the access alignment (half clears bit0, word clears bits[1:0]).

Structure
REQ-031 Shared package mem_pkg: size encoding constants (SZ_BYTE, SZ_HALF, SZ_WORD) and the M0-to-M1 stage struct typedef.
REQ-032 One sub-module mem_pipe_ram: DEPTH x 32 synchronous-write RAM with 4 byte enables, two-port write mux (init/pipeline) and combinational read.

Verification
REQ-033 Init word 5 = 0x8899AABB, then load word rega=0x10, imed=4 -> after 2 edges wbvalue=0x8899AABB, oper pulse of 1 cycle.
REQ-034 Store byte 0x7F at addr 0x15, then signed byte load 0x14..0x17 -> 0xFFFFFFBB, 0x0000007F, 0xFFFFFF99, 0xFFFFFF88.
REQ-035 Back-to-back store word 0x12345678 to addr 0x20 then load addr 0x20 -> 0x12345678 on the second output cycle.
REQ-036 Assert ram_init_en for 3 cycles with op in M0 -> ready=0, three bubbles on mem_wb_oper, held op emerges afterward unchanged.
REQ-037 With MEM_MISALIGN_TRAP_EN, word store to 0x22 -> misalign=1, RAM unchanged; without, store lands at word 0x20.
REQ-038 Reset low mid-stream with 2 ops in flight -> all outputs 0 immediately, no RAM write, no output after release.
